alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles in WAIT without alu_done before abort.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream offers instr this cycle.
REQ-005 instr  input  32  RISC-V instruction word.
REQ-006 instr_ready  output  1  high only in IDLE; transfer when instr_valid && instr_ready at posedge.
REQ-007 rf_raddr1 / rf_raddr2  output  5 each  register-file read addresses = latched instr[19:15] / instr[24:20].
REQ-008 rf_rdata1 / rf_rdata2  input  32 each  combinational register-file read data.
REQ-009 alu_start  output  1  registered start level to ALU; ALU acts on its rising edge.
REQ-010 alu_fun7 / alu_fun3  output  7 / 3  registered ALU operation select.
REQ-011 alu_rs1 / alu_rs2  output  32 each  registered ALU operands.
REQ-012 alu_res  input  32  ALU result.
REQ-013 alu_done  input  1  ALU completion; cleared by ALU on falling alu_start.
REQ-014 wb_en / wb_rd / wb_data  output  1 / 5 / 32  register-file write port.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 illegal  output  1  one-cycle pulse on unsupported opcode.
REQ-017 timeout_err  output  1  one-cycle pulse on ALU timeout abort.

Function
REQ-018 States: IDLE, OPRD, WAIT, WB, ABORT; encoding free.
REQ-019 IDLE: on transfer, latch instr; if opcode instr[6:0] is 0110011 (OP) or 0010011 (OP-IMM) go OPRD, else pulse illegal next cycle and stay IDLE.
REQ-020 OPRD (one cycle): alu_rs1 <= rf_rdata1; alu_fun3 <= instr[14:12]; alu_start <= 1; go WAIT.
REQ-021 OP: alu_rs2 <= rf_rdata2; alu_fun7 <= instr[31:25].
REQ-022 OP-IMM with fun3 001 or 101: alu_rs2 <= {27'b0, instr[24:20]}; alu_fun7 <= instr[31:25].
REQ-023 OP-IMM other fun3: alu_rs2 <= sign-extended instr[31:20]; alu_fun7 <= 0 (ADDI never subtracts).
REQ-024 OP with fun3 001 or 101: alu_rs2 <= {27'b0, rf_rdata2[4:0]} (shift amount masked to 5 bits).
REQ-025 WAIT: counter cleared on entry, +1 per cycle; alu_done sampled 1 -> latch alu_res, alu_start <= 0, go WB.
REQ-026 WAIT: counter reaching TIMEOUT with alu_done still 0 -> alu_start <= 0, go ABORT.
REQ-027 alu_done sampled 1 in the same cycle the counter reaches TIMEOUT -> done wins, go WB.
REQ-028 WB (one cycle): wb_en = 1 iff rd (instr[11:7]) != 0; wb_rd = rd; wb_data = latched result; go IDLE.
REQ-029 ABORT (one cycle): timeout_err = 1, wb_en = 0; go IDLE.
REQ-030 Latency: transfer at edge T -> alu_start high after T+1 -> with same-cycle ALU, WB during T+2..T+3 -> instr_ready high after T+3; one instruction per 3 cycles max.
REQ-031 alu_done is ignored outside WAIT; alu_start held stable (no glitch) for whole of WAIT.
REQ-032 wb_en, illegal, timeout_err are never high in the same cycle.
REQ-033 No new instruction is accepted while busy; instr changes while busy have no effect.

Reset
REQ-034 Reset asserted: immediately state IDLE; alu_start, wb_en, illegal, timeout_err, busy = 0; alu_rs1, alu_rs2, alu_fun3, alu_fun7, wb_rd, wb_data, counter = 0; instr_ready = 0 while reset high.
REQ-035 Reset mid-operation (OPRD/WAIT/WB): alu_start falls asynchronously, no writeback occurs, pending instruction discarded.
REQ-036 First transfer is possible at the first posedge after reset deasserts.

Verification
REQ-037 ADD x3,x1,x2 (0x002081B3), x1=5, x2=7, ALU done same cycle -> wb_en=1, wb_rd=3, wb_data=12 at T+2; alu_fun7=0, alu_fun3=000.
REQ-038 ADDI x5,x0,-1 (0xFFF00293) -> alu_rs2=0xFFFFFFFF, alu_fun7=0; SRAI x6,x1,4 (0x4040D313) -> alu_rs2=4, alu_fun7=0100000.
REQ-039 SLL x4,x1,x2 with x2=0x00000023 -> alu_rs2=3.
REQ-040 ADD with rd=x0 -> ALU started, wb_en stays 0, returns IDLE after WB.
REQ-041 Opcode 0000011 -> illegal pulse, alu_start never rises; alu_done held 0 after valid OP -> timeout_err pulse after 16 WAIT cycles, no writeback.
REQ-042 Reset asserted during WAIT -> alu_start=0 same cycle, busy=0, wb_en never asserted; next ADD completes normally.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: single-issue front end for an external multi-cycle ALU.
// Accepts RISC-V OP / OP-IMM instructions, reads the register file, drives
// registered operands and a start level to the ALU, waits for completion with
// a timeout, then writes the result back. Unsupported opcodes pulse illegal.
module alu_issue #(
   parameter int unsigned TIMEOUT = 16  // must be >= 1
) (
   input  logic        clk,
   input  logic        reset,
   // Instruction handshake
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   // Register-file read port (combinational data)
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   input  logic [31:0] rf_rdata1,
   input  logic [31:0] rf_rdata2,
   // ALU interface
   output logic        alu_start,
   output logic [6:0]  alu_fun7,
   output logic [2:0]  alu_fun3,
   output logic [31:0] alu_rs1,
   output logic [31:0] alu_rs2,
   input  logic [31:0] alu_res,
   input  logic        alu_done,
   // Register-file write port
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   // Status
   output logic        busy,
   output logic        illegal,
   output logic        timeout_err
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [6:0] OpcOp    = 7'b0110011;
   localparam logic [6:0] OpcOpImm = 7'b0010011;

   typedef enum logic [2:0] {
      StIdle,
      StOprd,
      StWait,
      StWb,
      StAbort
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic             start_q, start_d;
   logic [6:0]       fun7_q, fun7_d;
   logic [2:0]       fun3_q, fun3_d;
   logic [31:0]      rs1_q, rs1_d;
   logic [31:0]      rs2_q, rs2_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic [31:0]      wb_data_q, wb_data_d;
   logic             illegal_q, illegal_d;
   logic [CntW-1:0]  cnt_q, cnt_d;

   logic             transfer;
   logic             new_supported;
   logic             is_op;
   logic             is_shift;
   logic [31:0]      dec_rs2;
   logic [6:0]       dec_fun7;

   assign instr_ready   = (state_q == StIdle) && !reset;
   assign transfer      = instr_valid && instr_ready;
   assign new_supported = (instr[6:0] == OpcOp) || (instr[6:0] == OpcOpImm);

   assign is_op    = (instr_q[6:0] == OpcOp);
   assign is_shift = (instr_q[14:12] == 3'b001) || (instr_q[14:12] == 3'b101);

   // Second-operand and fun7 selection for the latched instruction.
   always_comb begin
      dec_rs2  = rf_rdata2;
      dec_fun7 = instr_q[31:25];
      if (is_op) begin
         // Register shifts only use the low five bits of rs2.
         if (is_shift) begin
            dec_rs2 = {27'b0, rf_rdata2[4:0]};
         end
      end else begin
         if (is_shift) begin
            dec_rs2 = {27'b0, instr_q[24:20]};
         end else begin
            // Immediate forms: fun7 bits belong to the immediate, so never subtract.
            dec_rs2  = {{20{instr_q[31]}}, instr_q[31:20]};
            dec_fun7 = 7'b0;
         end
      end
   end

   // Next-state and datapath-load decisions.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      start_d   = start_q;
      fun7_d    = fun7_q;
      fun3_d    = fun3_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      illegal_d = 1'b0;
      cnt_d     = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (transfer) begin
               instr_d = instr;
               if (new_supported) begin
                  state_d = StOprd;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         StOprd: begin
            rs1_d   = rf_rdata1;
            rs2_d   = dec_rs2;
            fun3_d  = instr_q[14:12];
            fun7_d  = dec_fun7;
            start_d = 1'b1;
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // Completion takes priority over a coincident timeout.
            if (alu_done) begin
               wb_data_d = alu_res;
               wb_rd_d   = instr_q[11:7];
               start_d   = 1'b0;
               state_d   = StWb;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               cnt_d   = cnt_q + CntW'(1);
               start_d = 1'b0;
               state_d = StAbort;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StWb: begin
            state_d = StIdle;
         end
         StAbort: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers; reset drops alu_start immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         instr_q   <= '0;
         start_q   <= 1'b0;
         fun7_q    <= '0;
         fun3_q    <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         start_q   <= start_d;
         fun7_q    <= fun7_d;
         fun3_q    <= fun3_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   assign rf_raddr1   = instr_q[19:15];
   assign rf_raddr2   = instr_q[24:20];
   assign alu_start   = start_q;
   assign alu_fun7    = fun7_q;
   assign alu_fun3    = fun3_q;
   assign alu_rs1     = rs1_q;
   assign alu_rs2     = rs2_q;
   assign wb_en       = (state_q == StWb) && (wb_rd_q != 5'd0);
   assign wb_rd       = wb_rd_q;
   assign wb_data     = wb_data_q;
   assign busy        = (state_q != StIdle);
   assign illegal     = illegal_q;
   assign timeout_err = (state_q == StAbort);

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: small register file and ALU models around the DUT,
// one task per scenario with inline checks sampled on the falling edge.
module tb_alu_issue;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic [31:0] instr;
   logic        instr_ready;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic        alu_start;
   logic [6:0]  alu_fun7;
   logic [2:0]  alu_fun3;
   logic [31:0] alu_rs1, alu_rs2;
   logic [31:0] alu_res;
   logic        alu_done;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        busy, illegal, timeout_err;

   logic [31:0] regs [32];
   logic        alu_ack_en;
   int          checks;
   int          failures;

   localparam logic [31:0] InstrAdd   = 32'h002081B3;  // add  x3,x1,x2
   localparam logic [31:0] InstrAddi  = 32'hFFF00293;  // addi x5,x0,-1
   localparam logic [31:0] InstrSrai  = 32'h4040D313;  // srai x6,x1,4
   localparam logic [31:0] InstrSll   = 32'h00209233;  // sll  x4,x1,x2
   localparam logic [31:0] InstrAddX0 = 32'h00208033;  // add  x0,x1,x2
   localparam logic [31:0] InstrLw    = 32'h00002083;  // lw   x1,0(x0)

   alu_issue #(.TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .alu_start   (alu_start),
      .alu_fun7    (alu_fun7),
      .alu_fun3    (alu_fun3),
      .alu_rs1     (alu_rs1),
      .alu_rs2     (alu_rs2),
      .alu_res     (alu_res),
      .alu_done    (alu_done),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .busy        (busy),
      .illegal     (illegal),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];
   // Same-cycle ALU when enabled; never completes when disabled.
   assign alu_done  = alu_start & alu_ack_en;

   // Behavioural ALU for the operations exercised here.
   always_comb begin
      alu_res = alu_rs1 ^ alu_rs2;
      case (alu_fun3)
         3'b000: alu_res = alu_fun7[5] ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
         3'b001: alu_res = alu_rs1 << alu_rs2[4:0];
         3'b101: alu_res = alu_fun7[5] ? 32'($signed(alu_rs1) >>> alu_rs2[4:0])
                                       : alu_rs1 >> alu_rs2[4:0];
         default: alu_res = alu_rs1 ^ alu_rs2;
      endcase
   end

   // Offer one instruction; returns at the falling edge after the transfer edge.
   task automatic issue(input logic [31:0] w);
      @(negedge clk);
      instr       = w;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      instr_valid = 1'b0;
      instr       = '0;
      alu_ack_en  = 1'b1;
      reset       = 1'b0;
      #2 reset    = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({alu_start, wb_en, illegal, timeout_err, busy, instr_ready} !== 6'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {alu_start, wb_en, illegal, timeout_err, busy, instr_ready});
      end
      checks++;
      if ({alu_rs1, alu_rs2, alu_fun3, alu_fun7, wb_rd, wb_data} !== '0) begin
         failures++;
         $display("FAIL reset_data: rs1=%h rs2=%h f3=%h f7=%h rd=%h data=%h want all 0",
                  alu_rs1, alu_rs2, alu_fun3, alu_fun7, wb_rd, wb_data);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (instr_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_ready: got %b want 1", instr_ready);
      end
   endtask

   task automatic test_add;
      @(negedge clk);
      instr       = InstrAdd;
      instr_valid = 1'b1;
      @(posedge clk);
      // Changing the offered word while busy must not disturb the accepted one.
      #1 instr = 32'h00000013;
      @(negedge clk);
      checks++;
      if ({busy, instr_ready, alu_start} !== 3'b100) begin
         failures++;
         $display("FAIL add_oprd_ctrl: got %b want 100", {busy, instr_ready, alu_start});
      end
      checks++;
      if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
         failures++;
         $display("FAIL add_raddr: got %0d/%0d want 1/2", rf_raddr1, rf_raddr2);
      end
      @(negedge clk);
      checks++;
      if (alu_start !== 1'b1 || alu_rs1 !== 32'd5 || alu_rs2 !== 32'd7) begin
         failures++;
         $display("FAIL add_operands: start=%b rs1=%h rs2=%h want 1/5/7",
                  alu_start, alu_rs1, alu_rs2);
      end
      checks++;
      if (alu_fun3 !== 3'b000 || alu_fun7 !== 7'b0) begin
         failures++;
         $display("FAIL add_fun: f3=%b f7=%b want 000/0000000", alu_fun3, alu_fun7);
      end
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12 || alu_start !== 1'b0) begin
         failures++;
         $display("FAIL add_wb: en=%b rd=%0d data=%h start=%b want 1/3/c/0",
                  wb_en, wb_rd, wb_data, alu_start);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({instr_ready, busy, wb_en} !== 3'b100) begin
         failures++;
         $display("FAIL add_idle: got %b want 100", {instr_ready, busy, wb_en});
      end
   endtask

   task automatic test_imm;
      issue(InstrAddi);
      @(negedge clk);
      checks++;
      if (alu_rs1 !== 32'd0 || alu_rs2 !== 32'hFFFFFFFF || alu_fun7 !== 7'b0 ||
          alu_fun3 !== 3'b000) begin
         failures++;
         $display("FAIL addi_operands: rs1=%h rs2=%h f7=%b f3=%b want 0/ffffffff/0/000",
                  alu_rs1, alu_rs2, alu_fun7, alu_fun3);
      end
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hFFFFFFFF) begin
         failures++;
         $display("FAIL addi_wb: en=%b rd=%0d data=%h want 1/5/ffffffff", wb_en, wb_rd, wb_data);
      end
      @(negedge clk);
      issue(InstrSrai);
      @(negedge clk);
      checks++;
      if (alu_rs1 !== 32'd5 || alu_rs2 !== 32'd4 || alu_fun7 !== 7'b0100000 ||
          alu_fun3 !== 3'b101) begin
         failures++;
         $display("FAIL srai_operands: rs1=%h rs2=%h f7=%b f3=%b want 5/4/0100000/101",
                  alu_rs1, alu_rs2, alu_fun7, alu_fun3);
      end
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 32'd0) begin
         failures++;
         $display("FAIL srai_wb: en=%b rd=%0d data=%h want 1/6/0", wb_en, wb_rd, wb_data);
      end
      @(negedge clk);
   endtask

   task automatic test_shift;
      regs[2] = 32'h00000023;
      issue(InstrSll);
      @(negedge clk);
      checks++;
      if (alu_rs2 !== 32'd3 || alu_fun3 !== 3'b001 || alu_fun7 !== 7'b0) begin
         failures++;
         $display("FAIL sll_operands: rs2=%h f3=%b f7=%b want 3/001/0", alu_rs2, alu_fun3,
                  alu_fun7);
      end
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h28) begin
         failures++;
         $display("FAIL sll_wb: en=%b rd=%0d data=%h want 1/4/28", wb_en, wb_rd, wb_data);
      end
      @(negedge clk);
      regs[2] = 32'd7;
   endtask

   task automatic test_rd_zero;
      issue(InstrAddX0);
      @(negedge clk);
      checks++;
      if (alu_start !== 1'b1) begin
         failures++;
         $display("FAIL rd0_start: got %b want 1", alu_start);
      end
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rd0_wb: en=%b busy=%b want 0/1", wb_en, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || instr_ready !== 1'b1) begin
         failures++;
         $display("FAIL rd0_idle: busy=%b ready=%b want 0/1", busy, instr_ready);
      end
   endtask

   task automatic test_illegal;
      logic rose;
      issue(InstrLw);
      checks++;
      if ({illegal, busy, instr_ready, alu_start} !== 4'b1010) begin
         failures++;
         $display("FAIL illegal_pulse: got %b want 1010", {illegal, busy, instr_ready, alu_start});
      end
      rose = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (alu_start !== 1'b0 || illegal !== 1'b0) rose = 1'b1;
      end
      checks++;
      if (rose !== 1'b0) begin
         failures++;
         $display("FAIL illegal_after: start or illegal high after pulse, got 1 want 0");
      end
   endtask

   task automatic test_timeout;
      logic bad;
      alu_ack_en = 1'b0;
      issue(InstrAdd);
      bad = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (alu_start !== 1'b1 || timeout_err !== 1'b0 || wb_en !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL timeout_wait: 16 wait cycles disturbed, got 1 want 0");
      end
      @(negedge clk);
      checks++;
      if ({timeout_err, alu_start, wb_en, busy} !== 4'b1001) begin
         failures++;
         $display("FAIL timeout_abort: got %b want 1001", {timeout_err, alu_start, wb_en, busy});
      end
      @(negedge clk);
      checks++;
      if ({timeout_err, busy} !== 2'b00) begin
         failures++;
         $display("FAIL timeout_idle: got %b want 00", {timeout_err, busy});
      end
      alu_ack_en = 1'b1;
   endtask

   task automatic test_done_at_limit;
      alu_ack_en = 1'b0;
      issue(InstrAdd);
      for (int k = 1; k <= 15; k++) @(negedge clk);
      @(negedge clk);
      alu_ack_en = 1'b1;
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || timeout_err !== 1'b0 || wb_data !== 32'd12) begin
         failures++;
         $display("FAIL done_at_limit: en=%b terr=%b data=%h want 1/0/c", wb_en, timeout_err,
                  wb_data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic wrote;
      alu_ack_en = 1'b0;
      issue(InstrAdd);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({alu_start, busy, instr_ready} !== 3'b000) begin
         failures++;
         $display("FAIL reset_mid: got %b want 000", {alu_start, busy, instr_ready});
      end
      @(negedge clk);
      reset      = 1'b0;
      alu_ack_en = 1'b1;
      wrote      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (wb_en !== 1'b0 || busy !== 1'b0) wrote = 1'b1;
      end
      checks++;
      if (wrote !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_discard: activity after reset, got 1 want 0");
      end
      issue(InstrAdd);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd12) begin
         failures++;
         $display("FAIL reset_mid_next: en=%b rd=%0d data=%h want 1/3/c", wb_en, wb_rd, wb_data);
      end
      @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int r = 0; r < 32; r++) regs[r] = 32'd0;
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      test_reset();
      test_add();
      test_imm();
      test_shift();
      test_rd_zero();
      test_illegal();
      test_timeout();
      test_done_at_limit();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
